// File: rtl/mlt3_tx_scheduler.sv
// MLT-3 transmit sequencer: frames parallel words as sync/data/[parity]/gap bits and steps a 2-bit line code.
// Optional even-parity bit enabled by defining MLT3_TX_PARITY_EN.
`timescale 1ns/1ps
module mlt3_tx_scheduler #(
  parameter int DATA_W   = 8,
  parameter int SYNC_LEN = 4,
  parameter int GAP_LEN  = 2,
  parameter int BIT_DIV  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [1:0]        code,
  output logic              bit_strobe,
  output logic              busy,
  output logic              frame_done
);

  localparam int MAX_A   = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
  localparam int MAX_L   = (MAX_A > GAP_LEN) ? MAX_A : GAP_LEN;
  localparam int CNT_W   = $clog2(MAX_L) + 1;
  localparam int DIV_SAFE = (BIT_DIV < 1) ? 1 : BIT_DIV;
  localparam int DIV_W   = $clog2(DIV_SAFE) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV_SAFE - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

  if (BIT_DIV < 1) begin : g_bad_div
    $error("mlt3_tx_scheduler: BIT_DIV must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
`ifdef MLT3_TX_PARITY_EN
    PARITY,
`endif
    GAP
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   shreg;
`ifdef MLT3_TX_PARITY_EN
  logic                par_bit;
`endif

  // A '1' advances the level by one (mod 4); a '0' holds it.
  function automatic logic [1:0] code_step(input logic [1:0] c, input logic b);
    return c + {1'b0, b};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      code       <= 2'b00;
      s_ready    <= 1'b0;
      bit_strobe <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
`ifdef MLT3_TX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      bit_strobe <= 1'b0;
      frame_done <= 1'b0;
      if (state == IDLE) begin
        if (s_valid && s_ready) begin
          // The handshake edge already launches the first sync bit.
          state      <= SYNC;
          shreg      <= s_data;
`ifdef MLT3_TX_PARITY_EN
          par_bit    <= ^s_data;
`endif
          code       <= code_step(code, 1'b1);
          bit_strobe <= 1'b1;
          div_cnt    <= '0;
          bit_cnt    <= '0;
          s_ready    <= 1'b0;
          busy       <= 1'b1;
        end else begin
          s_ready <= 1'b1;
        end
      end else if (div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        case (state)
          SYNC: begin
            bit_strobe <= 1'b1;
            if (bit_cnt == SYNC_LAST) begin
              state   <= DATA;
              bit_cnt <= '0;
              code    <= code_step(code, shreg[0]);
              shreg   <= shreg >> 1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              code    <= code_step(code, 1'b1);
            end
          end
          DATA: begin
            bit_strobe <= 1'b1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
`ifdef MLT3_TX_PARITY_EN
              state   <= PARITY;
              code    <= code_step(code, par_bit);
`else
              state   <= GAP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              code    <= code_step(code, shreg[0]);
              shreg   <= shreg >> 1;
            end
          end
`ifdef MLT3_TX_PARITY_EN
          PARITY: begin
            bit_strobe <= 1'b1;
            state      <= GAP;
            bit_cnt    <= '0;
          end
`endif
          GAP: begin
            if (bit_cnt == GAP_LAST) begin
              // Frame ends; ready reopens in this same cycle for back-to-back words.
              state      <= IDLE;
              frame_done <= 1'b1;
              s_ready    <= 1'b1;
              busy       <= 1'b0;
              bit_cnt    <= '0;
            end else begin
              bit_strobe <= 1'b1;
              bit_cnt    <= bit_cnt + 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            busy    <= 1'b0;
            s_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mlt3_tx_scheduler.sv
// Scoreboard bench for mlt3_tx_scheduler: a BIT_DIV=1 and a BIT_DIV=3 instance checked against a bit-level model.
`timescale 1ns/1ps
module tb_mlt3_tx_scheduler;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] s_data;
  logic       valid;
  logic       sel;
  logic       s_valid1, s_valid3;
  logic       ready1, strobe1, busy1, done1;
  logic       ready3, strobe3, busy3, done3;
  logic [1:0] code1, code3;
  logic       o_ready, o_strobe, o_busy, o_done;
  logic [1:0] o_code;

  assign s_valid1 = valid & ~sel;
  assign s_valid3 = valid & sel;

  always_comb begin
    o_ready  = sel ? ready3  : ready1;
    o_strobe = sel ? strobe3 : strobe1;
    o_busy   = sel ? busy3   : busy1;
    o_done   = sel ? done3   : done1;
    o_code   = sel ? code3   : code1;
  end

  mlt3_tx_scheduler #(.DATA_W(8), .SYNC_LEN(4), .GAP_LEN(2), .BIT_DIV(1)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid1), .s_ready(ready1),
    .code(code1), .bit_strobe(strobe1), .busy(busy1), .frame_done(done1));

  mlt3_tx_scheduler #(.DATA_W(8), .SYNC_LEN(4), .GAP_LEN(2), .BIT_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid3), .s_ready(ready3),
    .code(code3), .bit_strobe(strobe3), .busy(busy3), .frame_done(done3));

`ifdef MLT3_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 4 + 8 + P + 2;

  typedef struct packed {
    logic [1:0] code;
    logic       strobe;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         failures = 0;
  logic [1:0] mcode1 = 2'b00;
  logic [1:0] mcode3 = 2'b00;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line code per clock for one frame, starting from the model's level.
  task automatic push_frame(input logic [7:0] w, input int div);
    logic [1:0]  c;
    logic [15:0] bits;
    int          nb;
    c  = sel ? mcode3 : mcode1;
    nb = 0;
    bits = '0;
    for (int i = 0; i < 4; i++) begin bits[nb] = 1'b1; nb++; end
    for (int i = 0; i < 8; i++) begin bits[nb] = w[i]; nb++; end
`ifdef MLT3_TX_PARITY_EN
    bits[nb] = ^w; nb++;
`endif
    for (int i = 0; i < 2; i++) begin bits[nb] = 1'b0; nb++; end
    for (int i = 0; i < nb; i++) begin
      if (bits[i]) c = c + 2'd1;
      for (int d = 0; d < div; d++) sbq.push_back('{code: c, strobe: (d == 0)});
    end
    if (sel) mcode3 = c; else mcode1 = c;
  endtask

  task automatic start_word(input logic [7:0] w);
    int n;
    n = 0;
    while (!o_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", {7'd0, o_ready}, 8'd1);
    s_data = w;
    valid  = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] w, input int div, input bit chain,
                           input logic [7:0] next, input int limit);
    int   total, n;
    exp_t e;
    push_frame(w, div);
    total = NBITS * div;
    n = (limit < total) ? limit : total;
    e = '0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        if (chain) s_data = next; else valid = 1'b0;
      end
      e = sbq.pop_front();
      chk("code",   {6'd0, o_code},   {6'd0, e.code});
      chk("strobe", {7'd0, o_strobe}, {7'd0, e.strobe});
      chk("busy",   {7'd0, o_busy},   8'd1);
      chk("ready_in_frame", {7'd0, o_ready}, 8'd0);
      chk("done_in_frame",  {7'd0, o_done},  8'd0);
    end
    if (n == total) begin
      @(posedge clk); #1;
      chk("frame_done", {7'd0, o_done},   8'd1);
      chk("done_busy",  {7'd0, o_busy},   8'd0);
      chk("done_ready", {7'd0, o_ready},  8'd1);
      chk("done_strobe",{7'd0, o_strobe}, 8'd0);
      chk("done_code",  {6'd0, o_code},   {6'd0, e.code});
    end else begin
      sbq.delete();
    end
  endtask

  initial begin
    sel    = 1'b0;
    valid  = 1'b0;
    s_data = 8'h00;
    rst    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_code",   {6'd0, o_code},   8'd0);
    chk("rst_ready",  {7'd0, o_ready},  8'd0);
    chk("rst_busy",   {7'd0, o_busy},   8'd0);
    chk("rst_strobe", {7'd0, o_strobe}, 8'd0);
    chk("rst_done",   {7'd0, o_done},   8'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ready_before_edge", {7'd0, o_ready}, 8'd0);
    @(posedge clk); #1;
    chk("ready_after_release", {7'd0, o_ready}, 8'd1);

    start_word(8'hA5); run_frame(8'hA5, 1, 1'b0, 8'h00, 999);
    start_word(8'h00); run_frame(8'h00, 1, 1'b0, 8'h00, 999);
    start_word(8'h07); run_frame(8'h07, 1, 1'b0, 8'h00, 999);

    // Back-to-back words, then abort the second one during its data bits.
    start_word(8'h01);
    run_frame(8'h01, 1, 1'b1, 8'h02, 999);
    run_frame(8'h02, 1, 1'b0, 8'h00, 6);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_code",  {6'd0, o_code},  8'd0);
    chk("abort_busy",  {7'd0, o_busy},  8'd0);
    chk("abort_ready", {7'd0, o_ready}, 8'd0);
    chk("abort_done",  {7'd0, o_done},  8'd0);
    mcode1 = 2'b00;
    mcode3 = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_abort_done", {7'd0, o_done}, 8'd0);
      chk("post_abort_busy", {7'd0, o_busy}, 8'd0);
      chk("post_abort_code", {6'd0, o_code}, 8'd0);
    end

    sel = 1'b1;
    start_word(8'hFF); run_frame(8'hFF, 3, 1'b0, 8'h00, 999);
    chk("div3_end_code", {6'd0, o_code}, {6'd0, mcode3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
